// File: rtl/dequant_block_writer.sv
// Zigzag-ordered quantized coefficients in, dequantized 16-bit words out to the pre-IDCT SRAM raster layout.
// Optional per-block completion pulse is enabled by defining M3_BLOCK_DONE_PULSE_EN.
module dequant_block_writer #(
    parameter logic [17:0] PRE_IDCT_OFFSET = 18'd76800,
    parameter logic [17:0] U_SEG_OFFSET    = 18'd153600,
    parameter logic [17:0] V_SEG_OFFSET    = 18'd192000,
    parameter int          Y_BLOCK_COLS    = 40,
    parameter int          UV_BLOCK_COLS   = 20,
    parameter int          BLOCK_ROWS      = 30
) (
    input  logic               CLOCK_50_I,
    input  logic               Reset,
    input  logic               m3_start,
    input  logic               q_sel,
    input  logic signed [15:0] coef_data,
    input  logic               coef_valid,
    output logic               coef_ready,
    output logic [17:0]        SRAM_address,
    output logic signed [15:0] SRAM_write_data,
    output logic               write_en_n,
    output logic               m3_finish
`ifdef M3_BLOCK_DONE_PULSE_EN
    ,
    output logic               block_done,
    output logic [11:0]        block_index
`endif
);

    localparam int DATA_W = 16;
    localparam int EXT_W  = 24;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0]  Y_COL_LAST  = 6'(Y_BLOCK_COLS - 1);
    localparam logic [5:0]  UV_COL_LAST = 6'(UV_BLOCK_COLS - 1);
    localparam logic [4:0]  ROW_LAST    = 5'(BLOCK_ROWS - 1);
    localparam logic [17:0] Y_ROW_W     = 18'(Y_BLOCK_COLS * 8);
    localparam logic [17:0] UV_ROW_W    = 18'(UV_BLOCK_COLS * 8);

    // Returns {row, col} as two octal digits.
    function automatic logic [5:0] zigzag(input logic [5:0] k);
        logic [5:0] rc;
        case (k)
            6'd0:  rc = 6'o00; 6'd1:  rc = 6'o01; 6'd2:  rc = 6'o10; 6'd3:  rc = 6'o20;
            6'd4:  rc = 6'o11; 6'd5:  rc = 6'o02; 6'd6:  rc = 6'o03; 6'd7:  rc = 6'o12;
            6'd8:  rc = 6'o21; 6'd9:  rc = 6'o30; 6'd10: rc = 6'o40; 6'd11: rc = 6'o31;
            6'd12: rc = 6'o22; 6'd13: rc = 6'o13; 6'd14: rc = 6'o04; 6'd15: rc = 6'o05;
            6'd16: rc = 6'o14; 6'd17: rc = 6'o23; 6'd18: rc = 6'o32; 6'd19: rc = 6'o41;
            6'd20: rc = 6'o50; 6'd21: rc = 6'o60; 6'd22: rc = 6'o51; 6'd23: rc = 6'o42;
            6'd24: rc = 6'o33; 6'd25: rc = 6'o24; 6'd26: rc = 6'o15; 6'd27: rc = 6'o06;
            6'd28: rc = 6'o07; 6'd29: rc = 6'o16; 6'd30: rc = 6'o25; 6'd31: rc = 6'o34;
            6'd32: rc = 6'o43; 6'd33: rc = 6'o52; 6'd34: rc = 6'o61; 6'd35: rc = 6'o70;
            6'd36: rc = 6'o71; 6'd37: rc = 6'o62; 6'd38: rc = 6'o53; 6'd39: rc = 6'o44;
            6'd40: rc = 6'o35; 6'd41: rc = 6'o26; 6'd42: rc = 6'o17; 6'd43: rc = 6'o27;
            6'd44: rc = 6'o36; 6'd45: rc = 6'o45; 6'd46: rc = 6'o54; 6'd47: rc = 6'o63;
            6'd48: rc = 6'o72; 6'd49: rc = 6'o73; 6'd50: rc = 6'o64; 6'd51: rc = 6'o55;
            6'd52: rc = 6'o46; 6'd53: rc = 6'o37; 6'd54: rc = 6'o47; 6'd55: rc = 6'o56;
            6'd56: rc = 6'o65; 6'd57: rc = 6'o74; 6'd58: rc = 6'o75; 6'd59: rc = 6'o66;
            6'd60: rc = 6'o57; 6'd61: rc = 6'o67; 6'd62: rc = 6'o76; default: rc = 6'o77;
        endcase
        return rc;
    endfunction

    function automatic logic [2:0] quant_shift(input logic q, input logic [3:0] s);
        logic [2:0] sh;
        if (!q) begin
            if (s == 4'd0)      sh = 3'd3;
            else if (s == 4'd1) sh = 3'd2;
            else if (s <= 4'd3) sh = 3'd3;
            else if (s <= 4'd5) sh = 3'd4;
            else if (s <= 4'd7) sh = 3'd5;
            else                sh = 3'd6;
        end else begin
            if (s == 4'd0)      sh = 3'd3;
            else if (s <= 4'd3) sh = 3'd1;
            else if (s <= 4'd5) sh = 3'd2;
            else if (s <= 4'd7) sh = 3'd3;
            else if (s <= 4'd9) sh = 3'd4;
            else                sh = 3'd5;
        end
        return sh;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [EXT_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > 24'sd32767)       r = 16'sh7FFF;
        else if (v < -24'sd32768) r = 16'sh8000;
        else                      r = v[DATA_W-1:0];
        return r;
    endfunction

    logic [1:0] state;
    logic       q_sel_lat;
    logic [5:0] k;
    logic [5:0] block_col;
    logic [4:0] block_row;
    logic [1:0] seg;

    logic                     vld_p0;
    logic [5:0]               rc_p0;
    logic [3:0]               sum_p0;
    logic signed [EXT_W-1:0]  scaled_p0;
    logic signed [DATA_W-1:0] data_p0;
    logic [17:0]              seg_base_p0;
    logic [17:0]              row_w_p0;
    logic [17:0]              addr_p0;
    logic [5:0]               col_last_p0;
    logic                     frame_last_p0;

    assign vld_p0 = coef_valid && coef_ready;

    // p0: accepted coefficient -> address and dequantized value
    always_comb begin
        rc_p0         = zigzag(k);
        sum_p0        = {1'b0, rc_p0[5:3]} + {1'b0, rc_p0[2:0]};
        scaled_p0     = EXT_W'(coef_data) <<< quant_shift(q_sel_lat, sum_p0);
        data_p0       = saturate(scaled_p0);
        seg_base_p0   = PRE_IDCT_OFFSET;
        row_w_p0      = Y_ROW_W;
        col_last_p0   = Y_COL_LAST;
        if (seg == 2'd1) begin
            seg_base_p0 = U_SEG_OFFSET;
            row_w_p0    = UV_ROW_W;
            col_last_p0 = UV_COL_LAST;
        end else if (seg != 2'd0) begin
            seg_base_p0 = V_SEG_OFFSET;
            row_w_p0    = UV_ROW_W;
            col_last_p0 = UV_COL_LAST;
        end
        addr_p0       = seg_base_p0 + 18'({block_row, rc_p0[5:3]}) * row_w_p0
                      + 18'({block_col, rc_p0[2:0]});
        frame_last_p0 = (seg == 2'd2) && (block_row == ROW_LAST)
                      && (block_col == col_last_p0) && (k == 6'd63);
    end

    // p1: registered SRAM write and control
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state           <= S_IDLE;
            q_sel_lat       <= 1'b0;
            k               <= '0;
            block_col       <= '0;
            block_row       <= '0;
            seg             <= '0;
            coef_ready      <= 1'b0;
            write_en_n      <= 1'b1;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            m3_finish       <= 1'b0;
        end else begin
            write_en_n <= !vld_p0;
            m3_finish  <= 1'b0;
            if (vld_p0) begin
                SRAM_address    <= addr_p0;
                SRAM_write_data <= data_p0;
            end
            case (state)
                S_IDLE: begin
                    if (m3_start) begin
                        q_sel_lat  <= q_sel;
                        k          <= '0;
                        block_col  <= '0;
                        block_row  <= '0;
                        seg        <= '0;
                        coef_ready <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (vld_p0) begin
                        if (k == 6'd63) begin
                            k <= '0;
                            if (block_col == col_last_p0) begin
                                block_col <= '0;
                                if (block_row == ROW_LAST) begin
                                    block_row <= '0;
                                    seg       <= seg + 2'd1;
                                end else begin
                                    block_row <= block_row + 5'd1;
                                end
                            end else begin
                                block_col <= block_col + 6'd1;
                            end
                        end else begin
                            k <= k + 6'd1;
                        end
                        if (frame_last_p0) begin
                            coef_ready <= 1'b0;
                            state      <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    m3_finish <= 1'b1;
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef M3_BLOCK_DONE_PULSE_EN
    localparam logic [11:0] U_BLK_BASE = 12'(Y_BLOCK_COLS * BLOCK_ROWS);
    localparam logic [11:0] V_BLK_BASE = 12'((Y_BLOCK_COLS + UV_BLOCK_COLS) * BLOCK_ROWS);

    logic [11:0] blk_base_p0;
    logic [11:0] blk_idx_p0;

    always_comb begin
        blk_base_p0 = (seg == 2'd0) ? 12'd0 : ((seg == 2'd1) ? U_BLK_BASE : V_BLK_BASE);
        blk_idx_p0  = blk_base_p0 + 12'(block_row) * 12'({6'd0, col_last_p0} + 12'd1)
                    + 12'(block_col);
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            block_done  <= 1'b0;
            block_index <= '0;
        end else begin
            block_done <= vld_p0 && (k == 6'd63);
            if (vld_p0 && (k == 6'd63)) block_index <= blk_idx_p0;
        end
    end
`endif

endmodule
